// File: rtl/vec_stream_tx.sv
// Purpose: buffers whole N-element vectors in two ping/pong slots and streams them out one element at a time.
// Latency: first element is offered one cycle after the vector is accepted into an empty buffer.
// Backpressure: output_ready low holds the current element; vec_ready drops only when both slots are occupied.
module vec_stream_tx #(
  parameter int N = 4,
  parameter int T = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic [N*T-1:0]      vec_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic signed [T-1:0] output_data,
  output logic                output_last
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t          occ_q, occ_d;
  logic          head_q, head_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [T-1:0]  slot_q [2][N];
  logic [T-1:0]  slot_d [2][N];

  logic accept;
  logic xfer;
  logic pop;
  logic wr_sel;
  logic at_last;

  // Handshake decode; vec_ready and output_valid come from registered occupancy only.
  always_comb begin
    vec_ready    = !reset && (occ_q != FULL);
    output_valid = !reset && (occ_q != EMPTY);
    at_last      = (idx_q == IW'(N - 1));
    output_data  = output_valid ? slot_q[head_q][idx_q] : '0;
    output_last  = output_valid && at_last;
    accept       = vec_valid && vec_ready;
    xfer         = output_valid && output_ready;
    pop          = xfer && at_last;
    // An empty buffer is written at the head; otherwise the head is busy and the partner slot takes the new vector.
    wr_sel       = (occ_q == ONE) ? ~head_q : head_q;
  end

  // Next occupancy, head pointer, element index and slot contents.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    idx_d  = idx_q;
    slot_d = slot_q;

    case (occ_q)
      EMPTY: if (accept) occ_d = ONE;
      ONE: begin
        if (accept && !pop)      occ_d = FULL;
        else if (!accept && pop) occ_d = EMPTY;
      end
      FULL:    if (pop) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase

    if (xfer) begin
      idx_d = at_last ? '0 : idx_q + IW'(1);
    end
    if (pop) begin
      head_d = ~head_q;
    end

    if (accept) begin
      for (int i = 0; i < N; i++) begin
        slot_d[wr_sel][i] = vec_data[i*T +: T];
      end
    end
  end

  // State registers with synchronous clear of both slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= EMPTY;
      head_q <= 1'b0;
      idx_q  <= '0;
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < N; i++) begin
          slot_q[s][i] <= '0;
        end
      end
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      idx_q  <= idx_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: tb/tb_vec_stream_tx.sv
// Bench for vec_stream_tx: element-queue reference model checked every cycle,
// plus directed scenarios with hand-computed element sequences and timings.
module tb_vec_stream_tx;

  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           vec_valid;
  logic           vec_ready;
  logic [N*T-1:0] vec_data;
  logic           output_valid;
  logic           output_ready;
  logic signed [T-1:0] output_data;
  logic           output_last;

  vec_stream_tx #(.N(N), .T(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .vec_data     (vec_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_last  (output_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [T-1:0] d;
    logic         l;
    int           c;
  } xfer_t;

  typedef struct {
    logic [T-1:0] d;
    logic         l;
  } elem_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  elem_t model_q[$];
  xfer_t xlog[$];
  int    alog[$];
  int    ev[12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [N*T-1:0] pack(input int a, input int b, input int c, input int d);
    return {d[T-1:0], c[T-1:0], b[T-1:0], a[T-1:0]};
  endfunction

  // Reference model: a flat FIFO of pending elements; a vector is N entries, the last one flagged.
  always @(negedge clk) begin
    int nvec;
    if (reset) begin
      chk("rst_vec_ready", vec_ready, 0);
      chk("rst_output_valid", output_valid, 0);
      chk("rst_output_data", output_data[T-1:0], 0);
      chk("rst_output_last", output_last, 0);
      model_q.delete();
    end else begin
      nvec = (model_q.size() + N - 1) / N;
      chk("model_output_valid", output_valid, model_q.size() != 0);
      chk("model_vec_ready", vec_ready, nvec < 2);
      if (model_q.size() != 0) begin
        chk("model_output_data", output_data[T-1:0], model_q[0].d);
        chk("model_output_last", output_last, model_q[0].l);
      end
      if (output_valid && output_ready && model_q.size() != 0) begin
        xlog.push_back('{d: output_data[T-1:0], l: output_last, c: cyc});
        void'(model_q.pop_front());
      end
      if (vec_valid && vec_ready) begin
        for (int i = 0; i < N; i++) begin
          model_q.push_back('{d: vec_data[i*T +: T], l: (i == N - 1)});
        end
        alog.push_back(cyc);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [N*T-1:0] v);
    bit acc;
    int n;
    vec_valid = 1'b1;
    vec_data  = v;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = vec_ready;
      @(posedge clk);
      #1;
      n++;
    end
    vec_valid = 1'b0;
    vec_data  = '0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_vec_timeout got=not_accepted exp=accepted (cycle %0d)", cyc);
    end
  endtask

  // Compares the logged transfers against ev[0..n-1]; start < 0 skips the timing check.
  task automatic chk_seq(input string nm, input int n, input int start);
    int e;
    chk({nm, "_count"}, xlog.size(), n);
    if (xlog.size() == n) begin
      for (int k = 0; k < n; k++) begin
        e = ev[k];
        chk({nm, "_data"}, xlog[k].d, e[T-1:0]);
        chk({nm, "_last"}, xlog[k].l, (k % N) == N - 1);
        if (start >= 0) chk({nm, "_cycle"}, xlog[k].c, start + k);
      end
    end
  endtask

  task automatic clear_logs();
    xlog.delete();
    alog.delete();
  endtask

  initial begin
    reset = 1'b1;
    vec_valid = 1'b0;
    vec_data = '0;
    output_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_vec_ready", vec_ready, 1);
    chk("post_reset_output_valid", output_valid, 0);
    @(posedge clk); #1;

    // Single vector, no backpressure.
    clear_logs();
    output_ready = 1'b1;
    send_vec(pack(1, -2, 3, -4));
    repeat (6) tick();
    ev = '{1, -2, 3, -4, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("single", 4, (alog.size() > 0) ? alog[0] + 1 : 0);

    // First element held for 5 cycles of backpressure.
    clear_logs();
    output_ready = 1'b0;
    send_vec(pack(1, -2, 3, -4));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_data", output_data[T-1:0], 16'h0001);
      chk("hold_valid", output_valid, 1);
      @(posedge clk); #1;
    end
    output_ready = 1'b1;
    repeat (6) tick();
    chk_seq("backpressure", 4, (alog.size() > 0) ? alog[0] + 6 : 0);

    // Back-to-back vectors stream without a bubble.
    clear_logs();
    send_vec(pack(1, 2, 3, 4));
    send_vec(pack(5, 6, 7, 8));
    repeat (10) tick();
    ev = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
    chk("b2b_accept_gap", (alog.size() == 2) ? alog[1] - alog[0] : -1, 1);
    chk_seq("b2b", 8, (alog.size() > 0) ? alog[0] + 1 : 0);

    // Both slots full: third vector waits for the first vector's last element.
    clear_logs();
    output_ready = 1'b0;
    send_vec(pack(11, 12, 13, 14));
    send_vec(pack(21, 22, 23, 24));
    vec_valid = 1'b1;
    vec_data = pack(31, 32, 33, 34);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_vec_ready", vec_ready, 0);
      @(posedge clk); #1;
    end
    output_ready = 1'b1;
    send_vec(pack(31, 32, 33, 34));
    repeat (14) tick();
    ev = '{11, 12, 13, 14, 21, 22, 23, 24, 31, 32, 33, 34};
    chk("full_third_accept", (alog.size() == 3 && xlog.size() >= 4) ? alog[2] - xlog[3].c : -1, 1);
    chk_seq("full", 12, (alog.size() > 0) ? alog[0] + 5 : 0);

    // Accept and pop on the same edge keep output contiguous.
    clear_logs();
    send_vec(pack(41, 42, 43, 44));
    repeat (3) tick();
    send_vec(pack(51, 52, 53, 54));
    repeat (8) tick();
    ev = '{41, 42, 43, 44, 51, 52, 53, 54, 0, 0, 0, 0};
    chk("swap_accept_gap", (alog.size() == 2) ? alog[1] - alog[0] : -1, 4);
    chk_seq("swap", 8, (alog.size() > 0) ? alog[0] + 1 : 0);

    // Reset after element index 1 has transferred discards the rest.
    clear_logs();
    send_vec(pack(10, 20, 30, 40));
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_vec_ready", vec_ready, 1);
    chk("midrst_output_valid", output_valid, 0);
    @(posedge clk); #1;
    repeat (5) tick();
    ev = '{10, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk("midrst_count", xlog.size(), 2);
    if (xlog.size() == 2) begin
      chk("midrst_e0", xlog[0].d, 16'd10);
      chk("midrst_e1", xlog[1].d, 16'd20);
    end

    // Extreme values pass bit-exact.
    clear_logs();
    send_vec(pack(-32768, 32767, 0, -1));
    repeat (6) tick();
    ev = '{-32768, 32767, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("extreme", 4, (alog.size() > 0) ? alog[0] + 1 : 0);
    if (xlog.size() == 4) begin
      chk("extreme_hex0", xlog[0].d, 16'h8000);
      chk("extreme_hex1", xlog[1].d, 16'h7FFF);
      chk("extreme_hex2", xlog[2].d, 16'h0000);
      chk("extreme_hex3", xlog[3].d, 16'hFFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
